// File: rtl/cpu16_pkg.sv
// Shared types and constants for the cpu16 controller: opcodes, FSM states,
// ICNT bit positions and small decode helpers.
package cpu16_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpLdi = 4'h4;
  localparam logic [3:0] OpBz  = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam int unsigned IcntAdd = 0;
  localparam int unsigned IcntSub = 1;
  localparam int unsigned IcntAnd = 2;
  localparam int unsigned IcntOr  = 3;

  function automatic logic [15:0] sext9(input logic [8:0] imm);
    return {{7{imm[8]}}, imm};
  endfunction

  // One-hot ALU select; zero for every opcode the ALU does not serve.
  function automatic logic [3:0] op_onehot(input logic [3:0] op);
    logic [3:0] oh;
    oh = 4'b0000;
    case (op)
      OpAdd:   oh[IcntAdd] = 1'b1;
      OpSub:   oh[IcntSub] = 1'b1;
      OpAnd:   oh[IcntAnd] = 1'b1;
      OpOr:    oh[IcntOr]  = 1'b1;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);
  endfunction

endpackage

// File: rtl/cpu16_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port,
// synchronous active-high clear.
module cpu16_regfile
  import cpu16_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  raddr_a_i,
  output logic [15:0] rdata_a_o,
  input  logic [2:0]  raddr_b_i,
  output logic [15:0] rdata_b_o,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i
);

  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  always_comb begin
    rf_d = rf_q;
    if (we_i) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_q <= '{default: 16'h0000};
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rdata_a_o = rf_q[raddr_a_i];
  assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/cpu16_ctrl.sv
// Multi-cycle 16-bit CPU controller (FETCH/DECODE/EXEC/HALTED) driving an external ALU.
// Define CPU16_BRANCH_EN to build the zero flag and the BZ instruction.
module cpu16_ctrl
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IREQ,
  output logic [15:0] IADDR,
  input  logic [15:0] IDATA,
  input  logic        IVALID,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ICNT,
  input  logic [15:0] ALU_OUT,
  output logic        HALT
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
`ifdef CPU16_BRANCH_EN
  logic        z_q, z_d;
`endif

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] imm_sext;
  logic [15:0] rdata_a, rdata_b;
  logic        rf_we;
  logic [15:0] rf_wdata;

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:9];
  assign rs       = ir_q[8:6];
  assign rt       = ir_q[5:3];
  assign imm_sext = sext9(ir_q[8:0]);
  assign IADDR    = pc_q;

  cpu16_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (RST),
    .raddr_a_i (rs),
    .rdata_a_o (rdata_a),
    .raddr_b_i (rt),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
`ifdef CPU16_BRANCH_EN
    z_d      = z_q;
`endif
    rf_we    = 1'b0;
    rf_wdata = ALU_OUT;
    IREQ     = 1'b0;
    ICNT     = 4'b0000;
    ALU_A    = 16'h0000;
    ALU_B    = 16'h0000;
    HALT     = 1'b0;

    unique case (state_q)
      StFetch: begin
        IREQ = 1'b1;
        if (IVALID) begin
          ir_d    = IDATA;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opa_d   = rdata_a;
        opb_d   = rdata_b;
        state_d = (op == OpHlt) ? StHalted : StExec;
      end
      StExec: begin
        ALU_A   = opa_q;
        ALU_B   = opb_q;
        ICNT    = op_onehot(op);
        pc_d    = pc_q + 16'd1;
        state_d = StFetch;
        if (is_alu_op(op)) begin
          rf_we = 1'b1;
`ifdef CPU16_BRANCH_EN
          z_d   = (ALU_OUT == 16'h0000);
`endif
        end else if (op == OpLdi) begin
          rf_we    = 1'b1;
          rf_wdata = imm_sext;
        end else if (op == OpJmp) begin
          pc_d = pc_q + imm_sext;
`ifdef CPU16_BRANCH_EN
        end else if ((op == OpBz) && z_q) begin
          pc_d = pc_q + imm_sext;
`endif
        end
      end
      StHalted: begin
        HALT = 1'b1;
      end
    endcase

    // Reset owns the edge: suppress requests, ALU drive and any register write.
    if (RST) begin
      IREQ  = 1'b0;
      ICNT  = 4'b0000;
      ALU_A = 16'h0000;
      ALU_B = 16'h0000;
      HALT  = 1'b0;
      rf_we = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      opa_q   <= 16'h0000;
      opb_q   <= 16'h0000;
`ifdef CPU16_BRANCH_EN
      z_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
`ifdef CPU16_BRANCH_EN
      z_q     <= z_d;
`endif
    end
  end

endmodule

// File: doc/cpu16_ctrl.md
CPU16_CTRL -- requirements
Module: cpu16_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port CLK, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port RST, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port IREQ, output, 1, instruction fetch request.
REQ-005 SHALL have port IADDR, output, 16, fetch address (current PC).
REQ-006 SHALL have port IDATA, input, 16, instruction word.
REQ-007 SHALL have port IVALID, input, 1, IDATA valid for this cycle.
REQ-008 SHALL have port ALU_A, output, 16, ALU operand A.
REQ-009 SHALL have port ALU_B, output, 16, ALU operand B.
REQ-010 SHALL have port ICNT, output, 4, one-hot ALU op: bit0 ADD, bit1 SUB, bit2 AND, bit3 OR.
REQ-011 SHALL have port ALU_OUT, input, 16, combinational ALU result.
REQ-012 SHALL have port HALT, output, 1, high while halted.

Function
REQ-013 Instruction word SHALL be: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9 (signed).
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LDI (rd <= sext(imm9)), 5 BZ, 6 JMP (PC <= PC+sext(imm9)), 15 HLT; all others NOP.
REQ-015 FSM SHALL have states FETCH, DECODE, EXEC, HALTED.
REQ-016 FETCH: IREQ=1, IADDR=PC held stable; on edge with IVALID=1 latch IDATA into IR, go DECODE; else stay.
REQ-017 DECODE: latch R[rs], R[rt] into operand registers; go EXEC; HLT goes HALTED.
REQ-018 EXEC: ALU_A/ALU_B = operand registers; ICNT = one-hot for opcodes 0-3, else 4'b0000; on the edge write ALU_OUT to R[rd], update PC, go FETCH.
REQ-019 Outside EXEC, ICNT SHALL be 4'b0000 and no ALU result SHALL be written.
REQ-020 Non-branch instructions SHALL set PC <= PC+1; PC arithmetic SHALL be modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-021 LDI SHALL write sext(imm9) to R[rd] in EXEC; NOP writes nothing.
REQ-022 Latency: ALU instruction SHALL take 3 cycles after the IVALID edge (DECODE, EXEC, back in FETCH with new PC).
REQ-023 rd equal to rs/rt SHALL read old value (write happens after operand latch).
REQ-024 HALTED: IREQ=0, HALT=1, ICNT=0; exits only via RST.
REQ-025 IVALID while IREQ=0 SHALL be ignored.

Reset
REQ-026 RST=1 at an edge SHALL set PC=RESET_PC, R0-R7=0, IR=0, Z=1, state FETCH; dominant over all other events.
REQ-027 During and after reset cycle: IREQ=0 during RST, ICNT=0, HALT=0, ALU_A=ALU_B=0.
REQ-028 Reset mid-fetch or mid-EXEC SHALL discard the instruction; no register write occurs on that edge.

Configuration
REQ-029 Macro CPU16_BRANCH_EN SHALL control BZ and the zero flag.
REQ-030 Defined: Z register updated in EXEC of opcodes 0-3 (Z = ALU_OUT==0); BZ sets PC <= PC+sext(imm9) if Z else PC+1.
REQ-031 Undefined: no Z register; opcode 5 SHALL behave as NOP.

Structure
REQ-032 Package cpu16_pkg SHALL hold opcode constants, FSM state encoding, ICNT bit indices (ADD=0, SUB=1, AND=2, OR=3).
REQ-033 Register file SHALL be sub-module cpu16_regfile: 8x16, two combinational read ports, one synchronous write port, synchronous reset clear.

Verification
REQ-034 Reset then LDI R1,5; LDI R2,3; SUB R3,R1,R2 -> ICNT=4'b0010 in EXEC with ALU_A=5, ALU_B=3; R3=2; PC=3.
REQ-035 IVALID withheld 4 cycles in FETCH -> IREQ=1, IADDR constant; IR unchanged; DECODE entered only after IVALID.
REQ-036 LDI R1,-1 (imm9=0x1FF) -> R1=0xFFFF; ADD R2,R1,R1 -> R2=0xFFFE.
REQ-037 With CPU16_BRANCH_EN: SUB R0,R1,R1 then BZ +4 at PC=0x0010 -> PC=0x0014; without macro -> PC=0x0011.
REQ-038 RESET_PC=16'hFFFF, NOP at 0xFFFF -> next IADDR=0x0000.
REQ-039 HLT -> HALT=1, IREQ=0 indefinitely; RST asserted in EXEC of an ADD -> no R[rd] write, PC=RESET_PC.
